// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide memory controller: FSM states, request/owner codes,
// transfer-length codes and the length-to-last-byte helper.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEM_RD  = 3'd1,
        ST_MEM_WR  = 3'd2,
        ST_RD_TAIL = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'b00,
        REQ_LOAD  = 2'b01,
        REQ_STORE = 2'b10
    } mem_req_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_MEM  = 2'b10
    } owner_e;

    localparam logic [LEN_W-1:0] LEN_1 = 3'd1;
    localparam logic [LEN_W-1:0] LEN_2 = 3'd2;
    localparam logic [LEN_W-1:0] LEN_4 = 3'd4;

    // Index of the final byte of a transfer; unsupported lengths move a full word.
    function automatic logic [CNT_W-1:0] last_idx(input logic [LEN_W-1:0] len);
        case (len)
            LEN_1:   return 2'd0;
            LEN_2:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// IF/MEM request bus plus the single-port byte RAM bus seen by mem_ctrl.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                if_request;
    logic [ADDR_W-1:0]   if_addr;
    logic [1:0]          mem_request;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LEN_W-1:0]    mem_len;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BYTE_W-1:0]   mem_ctrl_data;
    logic [1:0]          if_or_mem_o;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_done;
    logic                stall_req;
    logic [BYTE_W-1:0]   ram_din;
    logic [BYTE_W-1:0]   ram_dout;
    logic [ADDR_W-1:0]   ram_a;
    logic                ram_wr;

    modport slave (
        input  if_request, if_addr, mem_request, mem_addr, mem_len, mem_wdata, ram_din,
        output mem_ctrl_data, if_or_mem_o, mem_rdata, mem_done, stall_req,
               ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_request, if_addr, mem_request, mem_addr, mem_len, mem_wdata, ram_din,
        input  mem_ctrl_data, if_or_mem_o, mem_rdata, mem_done, stall_req,
               ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between instruction fetch (pass-through in IDLE)
// and multi-byte MEM loads/stores, assembling or splitting little-endian words.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [BYTE_W-1:0]   data_q;
    logic [1:0]          owner_q, owner_d;
    logic                done_q;

    logic [CNT_W-1:0]    last_c;
    logic [CNT_W-1:0]    prev_lane_c;
    logic [ADDR_W-1:0]   mem_a_c;
    logic [ADDR_W-1:0]   ram_a_c;
    logic [BYTE_W-1:0]   ram_dout_c;
    logic                ram_wr_c;
    logic                stall_c;

    assign last_c      = last_idx(bus.mem_len);
    assign prev_lane_c = cnt_q - 2'd1;
    assign mem_a_c     = bus.mem_addr + ADDR_W'(cnt_q);

    // Next state, byte-lane capture/select and RAM port steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        owner_d    = OWN_NONE;
        ram_a_c    = bus.if_addr;
        ram_wr_c   = 1'b0;
        ram_dout_c = '0;
        stall_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_request == REQ_LOAD) begin
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    state_d = ST_MEM_RD;
                end else if (bus.mem_request == REQ_STORE) begin
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_MEM_WR;
                end else if (bus.if_request) begin
                    owner_d = OWN_IF;
                end
            end
            ST_MEM_RD: begin
                stall_c = 1'b1;
                owner_d = OWN_MEM;
                ram_a_c = mem_a_c;
                // RAM returns a byte one cycle late, so lane cnt-1 arrives now.
                if (cnt_q != '0) rdata_d[{prev_lane_c, 3'b000} +: BYTE_W] = bus.ram_din;
                if (cnt_q == last_c) state_d = ST_RD_TAIL;
                else                 cnt_d   = cnt_q + 2'd1;
            end
            ST_RD_TAIL: begin
                stall_c = 1'b1;
                rdata_d[{cnt_q, 3'b000} +: BYTE_W] = bus.ram_din;
                state_d = ST_DONE;
            end
            ST_MEM_WR: begin
                stall_c    = 1'b1;
                ram_a_c    = mem_a_c;
                ram_wr_c   = 1'b1;
                ram_dout_c = bus.mem_wdata[{cnt_q, 3'b000} +: BYTE_W];
                if (cnt_q == last_c) state_d = ST_DONE;
                else                 cnt_d   = cnt_q + 2'd1;
            end
            ST_DONE: begin
                stall_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            data_q  <= '0;
            owner_q <= OWN_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            data_q  <= bus.ram_din;
            owner_q <= owner_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.ram_a         = ram_a_c;
    assign bus.ram_dout      = ram_dout_c;
    assign bus.ram_wr        = ram_wr_c & ~rst;
    assign bus.stall_req     = stall_c & ~rst;
    assign bus.mem_ctrl_data = data_q;
    assign bus.if_or_mem_o   = owner_q;
    assign bus.mem_rdata     = rdata_q;
    assign bus.mem_done      = done_q;

endmodule
